conv_mac16: RTL and testbench
=============================

# conv_mac16

Downstream consumer of the 16-channel weight-passing stage in the 3x3 convolution array. Each input beat carries the current kernel tap's 16 signed 8-bit weights and the matching 16 input pixels. The block sums the 16 products per beat and accumulates 9 beats (one full 3x3 kernel window) into one output pixel. It walks the 19x19 output plane and tags every result with its (X, Y) position. It emits a one-cycle finish pulse after the 361st result.

## Interface
Parameters:
- CH, 16, channels per beat (weight/pixel lanes)
- DW, 8, signed lane width
- KW, 3, kernel width/height (x, y range 0..KW-1)
- OW, 19, output plane width/height (X, Y range 0..OW-1)
- ACC_W, 24, signed accumulator/result width

Ports:
- clk  in  1  rising-edge clock
- xrst  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  one-cycle pulse, begins a frame when idle
- in_valid  in  1  beat present
- in_ready  out  1  beat accepted when in_valid && in_ready
- w_data  in  CH*DW  lane i = bits [i*DW +: DW], signed
- px_data  in  CH*DW  lane i = bits [i*DW +: DW], signed
- out_valid  out  1  result present
- out_ready  in  1  result consumed when out_valid && out_ready
- out_data  out  ACC_W  signed kernel-window sum
- out_X, out_Y  out  5  output-plane position of out_data
- x, y  out  2  kernel tap of the next beat to be accepted
- X, Y  out  5  output position of the window in progress
- busy  out  1  high in RUN
- finish  out  1  one-cycle pulse at end of frame

## Operation
- States:
  - IDLE: start -> RUN, and clears counters and accumulator.
  - RUN: last result handshake -> IDLE.
  - start while RUN is ignored.
- in_ready = busy && !(out_valid && !out_ready) && !frame_beats_done.
- frame_beats_done sets once beat (x,y,X,Y)=(2,2,18,18) has been accepted. It clears on start.
- Accepted beat:
  - beat_sum = sum over i of signed(w_i) * signed(px_i).
  - Each product is 16 bits; beat_sum is 20 bits, sign-extended to ACC_W.
  - acc <= (x==0 && y==0) ? beat_sum : acc + beat_sum. The first tap overwrites; it does not add to the previous window.
- Counter order per accepted beat: x fastest (0..2), then y (0..2), then X (0..18), then Y (0..18). Each counter wraps to 0 when it carries.
- At tap (2,2):
  - out_data <= acc + beat_sum.
  - out_X/out_Y <= the X/Y in progress.
  - out_valid <= 1.
- out_valid clears on the handshake unless a new result is loaded the same cycle. It cannot be reloaded while held, because in_ready is low then.
- Width rule: the worst case is 9 * 16 * 16384 = 2359296 < 2^23. No saturation; ACC_W=24 is exact for the defaults.
- finish pulses on the handshake of the result tagged (18,18). busy drops the same edge and the state returns to IDLE.
- Between frames: x, y, X, Y hold 0.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, out_X=0, out_Y=0, x=y=X=Y=0, busy=0, finish=0. State is IDLE and acc=0.
- start at edge t: busy=1 and in_ready=1 from t+1.
- Latency: the tap-(2,2) beat accepted at edge t gives out_valid=1 with its data after edge t.
- Throughput: one beat per cycle, one result per 9 beats when out_ready is held high.
- Back-pressure: while out_valid && !out_ready, the following hold stable:
  - in_ready=0
  - acc and all counters
  - out_data, out_X, out_Y
- Simultaneous result handshake and tap-(2,2) beat in the same cycle: the new result loads and out_valid stays 1.
- Reset asserted mid-frame: all state returns to its reset value immediately. No finish pulse; the partial window is discarded.
- in_valid while IDLE is ignored and nothing is accumulated.

## Test plan
- All lanes w=1, px=1, 3249 beats, out_ready=1 -> 361 results of 144. Results in raster order (0,0)..(18,18). finish pulses exactly once; busy=0 afterwards.
- All lanes w=-128, px=-128 -> every result is 2359296 (0x240000), no overflow.
- All lanes w=127, px=-128 -> every result is -2340864. Sign extension holds on out_data.
- Drop out_ready for 5 cycles after the first result -> in_ready=0 for those cycles. No beat lost; out_data stays 144. Results 2..361 are still correct.
- Random in_valid gaps plus tap-dependent data (w=x+3y, px=1 on lane 0 only) -> each result is 36. No cross-window carry.
- Assert xrst after 100 beats, then start -> all outputs return to reset values. A full frame then completes correctly; start pulsed mid-frame has no effect.

Source files
------------

// File: rtl/conv_mac16_if.sv
// Beat/result bus of the 3x3 convolution MAC stage: input handshake, result
// handshake, tap/position tags and frame status.
interface conv_mac16_if #(
    parameter int CH    = 16,
    parameter int DW    = 8,
    parameter int KW    = 3,
    parameter int OW    = 19,
    parameter int ACC_W = 24
);
    localparam int TW = $clog2(KW);
    localparam int PW = $clog2(OW);

    logic                 start;
    logic                 in_valid;
    logic                 in_ready;
    logic [CH*DW-1:0]     w_data;
    logic [CH*DW-1:0]     px_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_W-1:0]     out_data;
    logic [PW-1:0]        out_X;
    logic [PW-1:0]        out_Y;
    logic [TW-1:0]        x;
    logic [TW-1:0]        y;
    logic [PW-1:0]        X;
    logic [PW-1:0]        Y;
    logic                 busy;
    logic                 finish;

    modport master (
        output start, in_valid, w_data, px_data, out_ready,
        input  in_ready, out_valid, out_data, out_X, out_Y, x, y, X, Y, busy, finish
    );

    modport slave (
        input  start, in_valid, w_data, px_data, out_ready,
        output in_ready, out_valid, out_data, out_X, out_Y, x, y, X, Y, busy, finish
    );
endinterface

// File: rtl/conv_mac16.sv
// 16-lane signed MAC that folds 9 kernel taps into one output pixel and walks
// the full OW x OW output plane, tagging each result with its (X, Y).
module conv_mac16 #(
    parameter int CH    = 16,
    parameter int DW    = 8,
    parameter int KW    = 3,
    parameter int OW    = 19,
    parameter int ACC_W = 24
) (
    input  logic        clk,
    input  logic        xrst,
    conv_mac16_if.slave bus
);
    localparam int TW     = $clog2(KW);
    localparam int PW     = $clog2(OW);
    localparam int PROD_W = 2 * DW;
    localparam int SUM_W  = PROD_W + $clog2(CH);

    localparam logic [TW-1:0] TAP_LAST = TW'(KW - 1);
    localparam logic [PW-1:0] POS_LAST = PW'(OW - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [TW-1:0]            tap_x;
    logic [TW-1:0]            tap_y;
    logic [PW-1:0]            pos_x;
    logic [PW-1:0]            pos_y;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  out_data_q;
    logic [PW-1:0]            out_x_q;
    logic [PW-1:0]            out_y_q;
    logic                     out_valid_q;
    logic                     frame_done;
    logic                     finish_q;

    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W-1:0]  beat_sum;
    logic signed [ACC_W-1:0]  beat_ext;
    logic                     busy;
    logic                     in_ready;
    logic                     accept;
    logic                     out_hs;
    logic                     start_frame;
    logic                     tap_first;
    logic                     tap_last;
    logic                     last_result;

    assign busy        = (state == RUN);
    assign in_ready    = busy && !(out_valid_q && !bus.out_ready) && !frame_done;
    assign accept      = bus.in_valid && in_ready;
    assign out_hs      = out_valid_q && bus.out_ready;
    assign start_frame = (state == IDLE) && bus.start;
    assign tap_first   = (tap_x == '0) && (tap_y == '0);
    assign tap_last    = (tap_x == TAP_LAST) && (tap_y == TAP_LAST);
    assign last_result = out_hs && (out_x_q == POS_LAST) && (out_y_q == POS_LAST);

    // Products are 16-bit signed; the 16-lane sum needs 4 guard bits.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        beat_sum = '0;
        prod     = '0;
        for (int i = 0; i < CH; i++) begin
            prod     = $signed(bus.w_data[i*DW +: DW]) * $signed(bus.px_data[i*DW +: DW]);
            beat_sum = beat_sum + SUM_W'(prod);
        end
    end

    assign beat_ext = ACC_W'(beat_sum);

    always_ff @(posedge clk or negedge xrst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!xrst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start)   state_nxt = RUN;
            RUN:  if (last_result) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            tap_x       <= '0;
            tap_y       <= '0;
            pos_x       <= '0;
            pos_y       <= '0;
            acc         <= '0;
            out_data_q  <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_valid_q <= 1'b0;
            frame_done  <= 1'b0;
            finish_q    <= 1'b0;
        end else begin
            if (start_frame) begin
                tap_x      <= '0;
                tap_y      <= '0;
                pos_x      <= '0;
                pos_y      <= '0;
                acc        <= '0;
                frame_done <= 1'b0;
            end else if (accept) begin
                // First tap overwrites so no window leaks into the next.
                acc <= tap_first ? beat_ext : acc + beat_ext;
                if (tap_last) begin
                    out_data_q <= acc + beat_ext;
                    out_x_q    <= pos_x;
                    out_y_q    <= pos_y;
                    if ((pos_x == POS_LAST) && (pos_y == POS_LAST))
                        frame_done <= 1'b1;
                end
                if (tap_x != TAP_LAST) begin
                    tap_x <= tap_x + TW'(1);
                end else begin
                    tap_x <= '0;
                    if (tap_y != TAP_LAST) begin
                        tap_y <= tap_y + TW'(1);
                    end else begin
                        tap_y <= '0;
                        if (pos_x != POS_LAST) begin
                            pos_x <= pos_x + PW'(1);
                        end else begin
                            pos_x <= '0;
                            pos_y <= (pos_y == POS_LAST) ? '0 : pos_y + PW'(1);
                        end
                    end
                end
            end

            // A fresh result may land in the same cycle the previous one drains.
            if (accept && tap_last) out_valid_q <= 1'b1;
            else if (out_hs)        out_valid_q <= 1'b0;

            finish_q <= busy && last_result;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_X     = out_x_q;
    assign bus.out_Y     = out_y_q;
    assign bus.x         = tap_x;
    assign bus.y         = tap_y;
    assign bus.X         = pos_x;
    assign bus.Y         = pos_y;
    assign bus.busy      = busy;
    assign bus.finish    = finish_q;
endmodule

// File: tb/tb_conv_mac16.sv
// Directed bench for conv_mac16: full frames with constant and tap-dependent
// data, back-pressure, input gaps, mid-frame reset and ignored start.
`timescale 1ns/1ps
module tb_conv_mac16;
    localparam int CH    = 16;
    localparam int DW    = 8;
    localparam int KW    = 3;
    localparam int OW    = 19;
    localparam int ACC_W = 24;
    localparam int TAPS  = KW * KW;
    localparam int NRES  = OW * OW;

    logic clk  = 1'b0;
    logic xrst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    conv_mac16_if #(.CH(CH), .DW(DW), .KW(KW), .OW(OW), .ACC_W(ACC_W)) bus ();

    conv_mac16 #(.CH(CH), .DW(DW), .KW(KW), .OW(OW), .ACC_W(ACC_W)) dut (
        .clk  (clk),
        .xrst (xrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: 1*1, mode 1: -128*-128, mode 2: 127*-128, else w=x+3y with px=1 on lane 0
    task automatic set_data(input int mode, input int tx, input int ty);
        logic signed [DW-1:0] w;
        logic signed [DW-1:0] p;
        for (int i = 0; i < CH; i++) begin
            case (mode)
                0:       begin w = DW'(1);    p = DW'(1);    end
                1:       begin w = DW'(-128); p = DW'(-128); end
                2:       begin w = DW'(127);  p = DW'(-128); end
                default: begin w = DW'(tx + 3*ty); p = (i == 0) ? DW'(1) : DW'(0); end
            endcase
            bus.w_data[i*DW +: DW]  = w;
            bus.px_data[i*DW +: DW] = p;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"},  bus.in_ready,  0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_data"},  bus.out_data,  0);
        check({tag, "_out_pos"},   {bus.out_Y, bus.out_X}, 0);
        check({tag, "_taps"},      {bus.Y, bus.X, bus.y, bus.x}, 0);
        check({tag, "_busy"},      bus.busy,   0);
        check({tag, "_finish"},    bus.finish, 0);
    endtask

    task automatic run_frame(input int mode, input bit gaps, input bit stall,
                             input bit mid_start, input longint exp_val);
        int beats;
        int results;
        int cyc;
        int finishes;
        int stalled;
        int tap;
        int win;
        bit mid_done;
        beats = 0; results = 0; cyc = 0; finishes = 0; stalled = 0; mid_done = 0;

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("start_busy",     bus.busy,     1);
        check("start_in_ready", bus.in_ready, 1);

        while (results < NRES && cyc < 20000) begin
            tap = beats % TAPS;
            win = beats / TAPS;
            bus.in_valid = (beats < TAPS * NRES) && (!gaps || $urandom_range(0, 2) != 0);
            set_data(mode, tap % KW, tap / KW);
            bus.out_ready = 1'b1;
            if (stall && stalled < 5 && bus.out_valid && results == 0) begin
                bus.out_ready = 1'b0;
                stalled++;
            end
            if (mid_start && !mid_done && beats >= 500) begin
                bus.start = 1'b1;
                mid_done  = 1'b1;
            end

            @(negedge clk);
            if (bus.out_valid && !bus.out_ready) begin
                check("stall_in_ready", bus.in_ready, 0);
                check("stall_out_data", $signed(bus.out_data), exp_val);
            end
            if (bus.in_valid && bus.in_ready) begin
                check("beat_tap_pos", {bus.Y, bus.X, bus.y, bus.x},
                      {5'(win / OW), 5'(win % OW), 2'(tap / KW), 2'(tap % KW)});
                beats++;
            end
            if (bus.out_valid && bus.out_ready) begin
                check("result_data", $signed(bus.out_data), exp_val);
                check("result_pos", {bus.out_Y, bus.out_X},
                      {5'(results / OW), 5'(results % OW)});
                results++;
            end

            tick();
            bus.start = 1'b0;
            if (bus.finish) finishes++;
            cyc++;
        end

        if (results < NRES) check("frame_timeout_results", results, NRES);
        bus.in_valid = 1'b0;
        repeat (2) begin
            tick();
            if (bus.finish) finishes++;
        end
        check("finish_count",   finishes, 1);
        check("end_busy",       bus.busy, 0);
        check("end_in_ready",   bus.in_ready, 0);
        check("end_out_valid",  bus.out_valid, 0);
        check("end_taps",       {bus.Y, bus.X, bus.y, bus.x}, 0);
        if (stall) check("stall_cycles", stalled, 5);
    endtask

    task automatic reset_mid_frame();
        int beats;
        beats = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        set_data(0, 0, 0);
        for (int c = 0; c < 400 && beats < 100; c++) begin
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) beats++;
            tick();
        end
        check("pre_reset_beats", beats, 100);
        xrst = 1'b0;
        #1;
        check_reset_state("mid_reset");
        bus.in_valid = 1'b0;
        @(negedge clk);
        xrst = 1'b1;
        tick();
        check_reset_state("post_reset");
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.w_data    = '0;
        bus.px_data   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        xrst = 1'b1;
        tick();
        check_reset_state("reset");

        // Beats offered while idle must be ignored.
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        set_data(1, 0, 0);
        repeat (5) tick();
        check("idle_in_ready",  bus.in_ready, 0);
        check("idle_taps",      {bus.Y, bus.X, bus.y, bus.x}, 0);
        check("idle_out_valid", bus.out_valid, 0);
        bus.in_valid = 1'b0;

        run_frame(0, 1'b0, 1'b0, 1'b0, 144);
        run_frame(1, 1'b0, 1'b0, 1'b0, 2359296);
        run_frame(2, 1'b0, 1'b0, 1'b0, -2340864);
        run_frame(0, 1'b0, 1'b1, 1'b0, 144);
        run_frame(3, 1'b1, 1'b0, 1'b0, 36);
        reset_mid_frame();
        run_frame(0, 1'b0, 1'b0, 1'b1, 144);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
